// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary (non-power-of-two) depth,
// registered fill count, almost-full/almost-empty thresholds, synchronous
// flush and optional sticky overflow/underflow flags.
//
// Optional feature macro: SYNC_FIFO_ERR_EN
//   defined   -> ovf_o/udf_o are sticky registers cleared by err_clr_i
//   undefined -> ovf_o/udf_o tied low, err_clr_i ignored, no flag registers
//
// PTR_WIDTH must equal $clog2(DEPTH) and CNT_WIDTH must equal
// $clog2(DEPTH+1); the instantiating level is responsible for that.
// rd_data_o is a show-ahead read of the head entry and is undefined while
// empty_o is high. All status outputs are registered and are decoded from
// the next-state count, so none depends combinationally on the requests.

module sync_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned AFULL_THR  = 6,
    parameter int unsigned AEMPTY_THR = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  ovf_o,
    output logic                  udf_o,
    input  logic                  err_clr_i
);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    // Flag values while the FIFO is held in reset (count == 0)
    localparam logic AFULL_RST  = (AFULL_THR == 0);
    localparam logic AEMPTY_RST = 1'b1;

    // Storage (not reset)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers, count and registered status
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 afull_q, afull_d;
    logic                 aempty_q, aempty_d;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    // Advance a pointer with an explicit wrap at DEPTH-1
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Request acceptance, qualified by registered status only
    always_comb begin
        wr_acc = wr_en_i & ~full_q;
        rd_acc = rd_en_i & ~empty_q;
        mem_we = wr_acc & ~flush_i;
    end

    // Next-state pointers and count; flush overrides any transfer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Status decode from the next count so the flags land with the count
    always_comb begin
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (32'(count_d) >= 32'(AFULL_THR));
        aempty_d = (32'(count_d) <= 32'(AEMPTY_THR));
    end

    // Pointer, count and status registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= AFULL_RST;
            aempty_q <= AEMPTY_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Show-ahead head entry
    assign rd_data_o      = mem_q[rd_ptr_q];
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign count_o        = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags; a set in the same cycle as a clear wins
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en_i & full_q) begin
            ovf_d = 1'b1;
        end
        if (rd_en_i & empty_q) begin
            udf_d = 1'b1;
        end
    end

    // Error flag registers; flush leaves them untouched
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr_i;
    assign ovf_o          = 1'b0;
    assign udf_o          = 1'b0;
`endif

endmodule
